// File: rtl/pc_gen_bp_pkg.sv
// Shared definitions for the fetch PC generator: widths, reset vector,
// 2-bit predictor counter encodings and the init/run state enum.
package pc_gen_bp_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/pc_gen_bp_btb_array.sv
// Direct-mapped BTB storage: one fetch read port, one execute read port,
// one update write port and a per-entry clear port used by the init sweep.
module btb_array #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] f_idx,
  output logic             f_valid,
  output logic [TAG_W-1:0] f_tag,
  output logic [XLEN-1:0]  f_target,
  output logic [1:0]       f_ctr,
  input  logic [IDX_W-1:0] e_idx,
  output logic             e_valid,
  output logic [TAG_W-1:0] e_tag,
  output logic [XLEN-1:0]  e_target,
  output logic [1:0]       e_ctr,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);
  import pc_gen_bp_pkg::*;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Reads see the pre-edge contents, so a same-cycle update is invisible to lookup.
  always_comb begin
    f_valid  = valid_q[f_idx];
    f_tag    = tag_q[f_idx];
    f_target = target_q[f_idx];
    f_ctr    = ctr_q[f_idx];
    e_valid  = valid_q[e_idx];
    e_tag    = tag_q[e_idx];
    e_target = target_q[e_idx];
    e_ctr    = ctr_q[e_idx];
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
      ctr_q[clr_idx]   <= WNT;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch PC generator with a tagged, direct-mapped BTB predictor, stall
// support and execute-stage misprediction recovery.
module pc_gen_bp #(
  parameter int              XLEN        = pc_gen_bp_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = pc_gen_bp_pkg::RESET_PC,
  parameter int              BTB_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_branch_cond,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_cnt
);
  import pc_gen_bp_pkg::*;

  localparam int              IDX_W    = $clog2(BTB_ENTRIES);
  localparam int              TAG_W    = XLEN - IDX_W - 2;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BTB_ENTRIES - 1);
  localparam logic [XLEN-1:0]  FOUR     = XLEN'(4);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             run;
  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag_pc, e_tag_pc;
  logic             f_valid, e_valid;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic [XLEN-1:0]  f_target, e_target;
  logic [1:0]       f_ctr, e_ctr;
  logic             e_hit, is_jump, is_ctrl, actual_taken;

  logic             wr_en;
  logic [XLEN-1:0]  wr_target;
  logic [1:0]       wr_ctr;

  assign run         = (state_q == RUN);
  assign fetch_valid = run;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + FOUR;
  assign mispredict_cnt = cnt_q;

  assign f_idx    = pc_q[IDX_W+1:2];
  assign f_tag_pc = pc_q[XLEN-1:IDX_W+2];
  assign e_idx    = ex_pc[IDX_W+1:2];
  assign e_tag_pc = ex_pc[XLEN-1:IDX_W+2];

  btb_array #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .f_idx     (f_idx),
    .f_valid   (f_valid),
    .f_tag     (f_tag),
    .f_target  (f_target),
    .f_ctr     (f_ctr),
    .e_idx     (e_idx),
    .e_valid   (e_valid),
    .e_tag     (e_tag),
    .e_target  (e_target),
    .e_ctr     (e_ctr),
    .clr_en    (state_q == INIT),
    .clr_idx   (idx_q),
    .wr_en     (wr_en),
    .wr_idx    (e_idx),
    .wr_tag    (e_tag_pc),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  always_comb begin
    pred_taken  = f_valid && (f_tag == f_tag_pc) && f_ctr[1];
    pred_target = pred_taken ? f_target : pc_plus4;
  end

  assign is_jump      = ex_is_jal | ex_is_jalr;
  assign is_ctrl      = ex_is_branch | is_jump;
  assign actual_taken = is_jump | (ex_is_branch & ex_branch_cond);
  assign e_hit        = e_valid && (e_tag == e_tag_pc);

  // Any instruction predicted taken can redirect, including non-control aliases.
  always_comb begin
    redirect_pc = actual_taken ? ex_target : ex_pc + FOUR;
    redirect    = run && ex_valid &&
                  ((actual_taken != ex_pred_taken) ||
                   (actual_taken && (ex_target != ex_pred_target)));
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_target = e_target;
    wr_ctr    = e_ctr;
    if (run && ex_valid && is_ctrl) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (is_jump)           wr_ctr = ST;
        else if (actual_taken) wr_ctr = ctr_inc(e_ctr);
        else                   wr_ctr = ctr_dec(e_ctr);
        if (actual_taken) wr_target = ex_target;
      end else if (actual_taken) begin
        wr_en     = 1'b1;
        wr_target = ex_target;
        wr_ctr    = is_jump ? ST : WT;
      end
    end
  end

  // Redirect outranks stall; pred_target already falls back to pc+4.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        pc_d  = RESET_PC;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) state_d = RUN;
      end
      RUN: begin
        if (redirect)   pc_d = redirect_pc;
        else if (stall) pc_d = pc_q;
        else            pc_d = pred_target;
      end
    endcase
    if (redirect) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Self-checking bench for pc_gen_bp: directed scenarios plus randomized
// traffic compared against a behavioural BTB/PC model.
module tb_pc_gen_bp;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_valid, pred_taken, redirect;
  logic [31:0] pc, pc_plus4, pred_target, redirect_pc, mispredict_cnt;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_branch_cond, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_run = 1'b0;
  int          m_init_left = 0;
  bit          mv   [N];
  logic [31:0] mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];

  always #5 clk = ~clk;

  pc_gen_bp #(.XLEN(32), .RESET_PC(32'h0), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_valid(fetch_valid), .pc(pc),
    .pc_plus4(pc_plus4), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch_cond(ex_branch_cond),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    int i = midx(a);
    return mv[i] && (mtag[i] == (a >> 6)) && (mctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] a);
    return m_pred(a) ? mtgt[midx(a)] : a + 32'd4;
  endfunction

  function automatic bit m_taken();
    return ex_is_jal || ex_is_jalr || (ex_is_branch && ex_branch_cond);
  endfunction

  function automatic bit m_redirect();
    bit t;
    if (!m_run || !ex_valid) return 1'b0;
    t = m_taken();
    return (t != ex_pred_taken) || (t && (ex_target != ex_pred_target));
  endfunction

  function automatic logic [31:0] m_rpc();
    return m_taken() ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_step();
    bit r, t, jump, hit;
    logic [31:0] npc;
    int i;
    if (rst) begin
      m_pc = 32'h0; m_run = 1'b0; m_init_left = N; m_cnt = 32'd0;
      for (int k = 0; k < N; k++) mv[k] = 1'b0;
    end else if (!m_run) begin
      m_init_left--;
      if (m_init_left == 0) m_run = 1'b1;
    end else begin
      r = m_redirect();
      npc = r ? m_rpc() : (stall ? m_pc : m_ptgt(m_pc));
      if (r) m_cnt++;
      if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
        t = m_taken();
        jump = ex_is_jal || ex_is_jalr;
        i = midx(ex_pc);
        hit = mv[i] && (mtag[i] == (ex_pc >> 6));
        if (hit) begin
          if (jump) mctr[i] = 3;
          else if (t) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
          else mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
          if (t) mtgt[i] = ex_target;
        end else if (t) begin
          mv[i] = 1'b1; mtag[i] = ex_pc >> 6; mtgt[i] = ex_target; mctr[i] = jump ? 3 : 2;
        end
      end
      m_pc = npc;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_branch_cond = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  // Steers fetch to address a through a non-control instruction predicted taken.
  task automatic goto_pc(input logic [31:0] a);
    clear_ex(); stall = 0;
    ex_valid = 1; ex_pc = a - 32'd4; ex_pred_taken = 1; ex_pred_target = a;
    tick();
    clear_ex();
    #1;
  endtask

  task automatic resolve(input logic [31:0] epc, input bit br, input bit jalr, input bit cond,
                         input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
    clear_ex();
    ex_valid = 1; ex_pc = epc; ex_is_branch = br; ex_is_jalr = jalr; ex_branch_cond = cond;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; clear_ex();
    tick(); tick();
    rst = 0; #1;
    n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_fv: got %b exp 0", fetch_valid); end
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc: got %h exp 0", pc); end
    n_cmp++; if (mispredict_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d exp 0", mispredict_cnt); end
    for (int e = 1; e <= N; e++) begin
      if (e <= 8) begin ex_valid = 1; ex_pc = 32'h10; ex_pred_taken = 1; ex_pred_target = 32'h80; end
      else clear_ex();
      #1;
      n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL init_redirect: got %b exp 0", redirect); end
      tick();
      n_cmp++; if (fetch_valid !== (e == N)) begin n_fail++; $display("[TB] FAIL init_fv e=%0d: got %b exp %b", e, fetch_valid, e == N); end
      n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL init_pc e=%0d: got %h exp 0", e, pc); end
    end
    clear_ex();
    tick();
    n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("[TB] FAIL run_pc4: got %h exp 4", pc); end
    tick();
    n_cmp++; if (pc !== 32'h8) begin n_fail++; $display("[TB] FAIL run_pc8: got %h exp 8", pc); end
    n_cmp++; if (mispredict_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL run_cnt: got %0d exp 0", mispredict_cnt); end
  endtask

  task automatic test_cold_branch();
    resolve(32'h40, 1, 0, 1, 32'h100, 0, 32'h44);
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL cold_redirect: got %b exp 1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL cold_rpc: got %h exp 100", redirect_pc); end
    tick(); clear_ex(); #1;
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("[TB] FAIL cold_pc: got %h exp 100", pc); end
    n_cmp++; if (mispredict_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL cold_cnt: got %0d exp 1", mispredict_cnt); end
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL cold_pred: got %b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h100) begin n_fail++; $display("[TB] FAIL cold_ptgt: got %h exp 100", pred_target); end
    tick();
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("[TB] FAIL cold_follow: got %h exp 100", pc); end
  endtask

  task automatic test_hysteresis();
    resolve(32'h40, 1, 0, 0, 32'h100, 1, 32'h100);
    n_cmp++; if (redirect_pc !== 32'h44) begin n_fail++; $display("[TB] FAIL hyst_nt_rpc: got %h exp 44", redirect_pc); end
    tick();
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL hyst_wnt: got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h44) begin n_fail++; $display("[TB] FAIL hyst_wnt_tgt: got %h exp 44", pred_target); end
    resolve(32'h40, 1, 0, 1, 32'h100, 0, 32'h44); tick();
    resolve(32'h40, 1, 0, 1, 32'h100, 1, 32'h100);
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL hyst_correct: got %b exp 0", redirect); end
    tick();
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL hyst_st: got %b exp 1", pred_taken); end
    resolve(32'h40, 1, 0, 0, 32'h100, 1, 32'h100); tick();
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL hyst_wt: got %b exp 1", pred_taken); end
    resolve(32'h80, 1, 0, 0, 32'h300, 0, 32'h84);
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_nt_redirect: got %b exp 0", redirect); end
    tick();
    goto_pc(32'h80);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_nt_pred: got %b exp 0", pred_taken); end
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_nt_keep: got %b exp 1", pred_taken); end
    n_cmp++; if (mispredict_cnt !== m_cnt) begin n_fail++; $display("[TB] FAIL hyst_cnt: got %0d exp %0d", mispredict_cnt, m_cnt); end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] held;
    clear_ex(); #1;
    held = pc;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (pc !== held) begin n_fail++; $display("[TB] FAIL stall_hold k=%0d: got %h exp %h", k, pc, held); end
    end
    resolve(32'h504, 0, 1, 0, 32'h2000, 0, 32'h508);
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_redir: got %b exp 1", redirect); end
    tick();
    n_cmp++; if (pc !== 32'h2000) begin n_fail++; $display("[TB] FAIL stall_redir_pc: got %h exp 2000", pc); end
    stall = 0; clear_ex();
  endtask

  task automatic test_target_mismatch();
    resolve(32'h508, 0, 1, 0, 32'h200, 0, 32'h50C); tick();
    goto_pc(32'h508);
    n_cmp++; if (pred_target !== 32'h200) begin n_fail++; $display("[TB] FAIL jalr_alloc: got %h exp 200", pred_target); end
    resolve(32'h508, 0, 1, 0, 32'h300, 1, 32'h200);
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL tgt_redirect: got %b exp 1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL tgt_rpc: got %h exp 300", redirect_pc); end
    tick();
    goto_pc(32'h508);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL tgt_pred: got %b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h300) begin n_fail++; $display("[TB] FAIL tgt_update: got %h exp 300", pred_target); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_plus4: got %h exp 0", pc_plus4); end
    n_cmp++; if (pred_target !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_ptgt: got %h exp 0", pred_target); end
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h exp 0", pc); end
    clear_ex(); ex_valid = 1; ex_pc = 32'hFFFF_FFFC; ex_pred_taken = 1; ex_pred_target = 32'h40; #1;
    n_cmp++; if (redirect_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_rpc: got %h exp 0", redirect_pc); end
    tick(); clear_ex();
  endtask

  task automatic test_alias_reset();
    goto_pc(32'h440);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL alias_pred: got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h444) begin n_fail++; $display("[TB] FAIL alias_ptgt: got %h exp 444", pred_target); end
    rst = 1; tick(); rst = 0; #1;
    n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_fv: got %b exp 0", fetch_valid); end
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_pc: got %h exp 0", pc); end
    n_cmp++; if (mispredict_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_cnt: got %0d exp 0", mispredict_cnt); end
    for (int k = 0; k < 5; k++) tick();
    rst = 1; tick(); rst = 0;
    for (int e = 1; e <= N; e++) begin
      tick();
      n_cmp++; if (fetch_valid !== (e == N)) begin n_fail++; $display("[TB] FAIL reinit_fv e=%0d: got %b exp %b", e, fetch_valid, e == N); end
    end
    goto_pc(32'h40);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL reinit_pred: got %b exp 0", pred_taken); end
  endtask

  task automatic test_random();
    int kind;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 3) == 0);
      clear_ex();
      ex_valid = ($urandom_range(0, 9) < 6);
      ex_pc = (32'($urandom_range(0, 47)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
      kind = $urandom_range(0, 3);
      ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
      ex_branch_cond = 1'($urandom_range(0, 1));
      ex_target = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken = m_pred(ex_pc); ex_pred_target = m_ptgt(ex_pc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = 32'($urandom_range(0, 255)) << 2;
      end
      #1;
      n_cmp++; if (fetch_valid !== m_run) begin n_fail++; $display("[TB] FAIL rnd_fv c=%0d: got %b exp %b", c, fetch_valid, m_run); end
      n_cmp++; if (pc !== m_pc) begin n_fail++; $display("[TB] FAIL rnd_pc c=%0d: got %h exp %h", c, pc, m_pc); end
      n_cmp++; if (mispredict_cnt !== m_cnt) begin n_fail++; $display("[TB] FAIL rnd_cnt c=%0d: got %0d exp %0d", c, mispredict_cnt, m_cnt); end
      n_cmp++; if (redirect !== m_redirect()) begin n_fail++; $display("[TB] FAIL rnd_redirect c=%0d: got %b exp %b", c, redirect, m_redirect()); end
      if (m_redirect()) begin
        n_cmp++; if (redirect_pc !== m_rpc()) begin n_fail++; $display("[TB] FAIL rnd_rpc c=%0d: got %h exp %h", c, redirect_pc, m_rpc()); end
      end
      if (m_run) begin
        n_cmp++; if (pred_taken !== m_pred(m_pc)) begin n_fail++; $display("[TB] FAIL rnd_pred c=%0d: got %b exp %b", c, pred_taken, m_pred(m_pc)); end
        n_cmp++; if (pred_target !== m_ptgt(m_pc)) begin n_fail++; $display("[TB] FAIL rnd_ptgt c=%0d: got %h exp %h", c, pred_target, m_ptgt(m_pc)); end
      end
      tick();
    end
    rst = 0; stall = 0; clear_ex();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; stall = 0; clear_ex();
    test_reset();
    test_cold_branch();
    test_hysteresis();
    test_stall_redirect();
    test_target_mismatch();
    test_wrap();
    test_alias_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen_bp.md
Name: pc_gen_bp

Overview:
- Next-generation fetch PC generator. Owns the architectural PC register instead of computing next-PC purely combinationally.
- Adds dynamic prediction: a direct-mapped, tagged BTB with 2-bit saturating counters. Also adds stall support and execute-stage misprediction recovery.
- Sits between the fetch stage (drives `pc`) and the execute stage (returns resolved branch/jump outcome).

Parameters:
- XLEN, 32, PC/data width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- BTB_ENTRIES, 64, number of BTB entries (power of two, >=2).
- IDX_W, $clog2(BTB_ENTRIES), index width (derived, localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold PC (fetch back-pressure).
- fetch_valid  out  1  PC is valid for fetch (low during reset/init sweep).
- pc  out  XLEN  current fetch PC (register).
- pc_plus4  out  XLEN  pc + 4.
- pred_taken  out  1  prediction for current pc (combinational).
- pred_target  out  XLEN  predicted target for current pc.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  XLEN  PC of execute-stage instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_branch_cond  in  1  branch condition true.
- ex_target  in  XLEN  computed target (ALU output).
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipeline.
- redirect  out  1  misprediction detected this cycle (flush younger stages).
- redirect_pc  out  XLEN  correct next PC on redirect.
- mispredict_cnt  out  32  wrapping misprediction counter.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, state=INIT, sweep idx=0, fetch_valid=0, mispredict_cnt=0.
  - redirect=0 whenever fetch_valid=0.
- FSM INIT:
  - Each cycle clears entry idx (valid=0, ctr=2'b01) and increments idx.
  - The edge that clears entry BTB_ENTRIES-1 moves the FSM to RUN.
  - fetch_valid=1 from that edge on, i.e. after exactly BTB_ENTRIES post-reset edges.
  - pc is held at RESET_PC throughout INIT.
  - rst asserted mid-INIT or mid-RUN restarts the sweep from idx 0.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN-1:0], ctr[1:0].
  - Index = pc[IDX_W+1:2].
  - Bits pc[1:0] are ignored.
- Lookup (combinational, from pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : pc_plus4.
- Resolution (only when ex_valid and RUN):
  - actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch_cond).
  - actual_next = actual_taken ? ex_target : ex_pc+4.
  - redirect = (actual_taken != ex_pred_taken) | (actual_taken & ex_target != ex_pred_target).
  - Non-control instructions can still redirect if they were predicted taken (stale alias).
  - redirect_pc = actual_next. Both are combinational, same cycle.
  - mispredict_cnt increments by 1 per redirect and wraps at 2^32.
- Update (registered, on the same edge, ex_valid & RUN & (branch|jal|jalr)):
  - Hit, taken: ctr saturating +1, target <= ex_target.
  - Hit, not taken: ctr saturating -1.
  - Hit, jal/jalr: ctr <= 2'b11.
  - Miss, taken: allocate valid=1, tag, target, ctr = jal/jalr ? 2'b11 : 2'b10.
  - Miss, not taken: no write.
- Next-PC priority (edge, RUN):
  1. redirect → redirect_pc
  2. stall → hold
  3. pred_taken → pred_target
  4. otherwise pc_plus4
- Redirect overrides stall in the same cycle.
- Same-index lookup and update in one cycle: lookup sees the pre-update contents (read-before-write).
- Width rules: all PC arithmetic is modulo 2^XLEN. pc+4 at 32'hFFFF_FFFC wraps to 0.

Decomposition:
- Shared package (e.g. `cpu_pkg`):
  - XLEN, RESET_PC.
  - 2-bit counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - FSM state enum {INIT, RUN}.
- One natural sub-module: `btb_array`, holding storage, combinational read port, write port and per-entry clear port. The top level keeps the FSM, PC register, redirect logic and counter.

Test Plan (BTB_ENTRIES=16):
- Init sweep: rst 2 cycles then release → fetch_valid=0 for 16 edges, then 1; pc=0, then 4, 8, …; mispredict_cnt=0.
- Cold branch:
  - Stimulus: ex_valid, ex_pc=0x40, ex_is_branch, ex_branch_cond=1, ex_target=0x100, ex_pred_taken=0.
  - Response: redirect=1, redirect_pc=0x100, next pc=0x100, mispredict_cnt=1.
  - Later fetch of 0x40: pred_taken=1, pred_target=0x100.
- Counter hysteresis:
  - Stimulus: resolve 0x40 not-taken once (ctr 10→01), fetch 0x40.
  - Response: pred_taken=0.
  - Then resolve taken twice: ctr 11, pred_taken=1.
  - Also: a not-taken miss at 0x80 allocates nothing; re-fetch of 0x80 gives pred_taken=0.
- Stall vs redirect:
  - stall=1 alone → pc holds 3 cycles.
  - stall=1 with a JALR redirect to 0x2000 in the same cycle → pc=0x2000 next edge.
- Target mismatch:
  - Stimulus: JALR, ex_pred_taken=1, ex_pred_target=0x200, ex_target=0x300.
  - Response: redirect=1, redirect_pc=0x300, BTB target updated to 0x300.
- Aliasing and mid-run reset:
  - 0x40 and 0x440 share an index; tag mismatch → no prediction for 0x440.
  - rst asserted in RUN → pc=RESET_PC, fetch_valid=0, 16-cycle sweep restarts, previously trained 0x40 predicts not-taken.
